// File: rtl/scope_capture_trig.sv
// Triggered multi-channel capture buffer: pre/post windows around an
// edge trigger with hysteresis, frozen frame for pixel-rate readout.
module scope_capture_trig #(
  parameter int DATA_W  = 8,
  parameter int CH      = 2,
  parameter int CH_W    = 1,
  parameter int ADDR_W  = 9,
  parameter int AUTO_TO = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH*DATA_W-1:0] din,
  input  logic                 din_valid,
  input  logic [1:0]           mode,
  input  logic                 arm,
  input  logic                 frame_ack,
  input  logic [CH_W-1:0]      trig_ch,
  input  logic                 trig_slope,
  input  logic [DATA_W-1:0]    trig_level,
  input  logic [DATA_W-1:0]    trig_hyst,
  input  logic [ADDR_W-1:0]    pre_len,
  input  logic [CH_W-1:0]      rd_ch,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 busy,
  output logic                 triggered,
  output logic                 forced,
  output logic                 done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TO_W  = $clog2(AUTO_TO + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]             state;
  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      pre_q;
  logic [ADDR_W-1:0]      cnt;
  logic [ADDR_W-1:0]      cnt_nxt;
  logic [ADDR_W-1:0]      trig_addr;
  logic [ADDR_W-1:0]      post_len;
  logic [ADDR_W-1:0]      rd_phys;
  logic [TO_W-1:0]        to_cnt;
  logic [TO_W-1:0]        to_nxt;
  logic                   arm_flag;
  logic [DATA_W-1:0]      s;
  logic [DATA_W-1:0]      lo;
  logic [DATA_W-1:0]      hi;
  logic [DATA_W:0]        hi_sum;
  logic [DATA_W-1:0]      rd_sel;
  logic [CH*DATA_W-1:0]   rd_word;
  logic                   beyond;
  logic                   hit;
  logic                   real_trig;
  logic                   auto_trig;
  logic                   stop_req;
  logic                   wr_en;
  logic                   start_cap;

  logic [CH*DATA_W-1:0] mem [DEPTH];

  always_comb begin
    s = '0;
    for (int k = 0; k < CH; k++)
      if (trig_ch == CH_W'(k)) s = din[k*DATA_W +: DATA_W];
  end

  // saturating hysteresis band around the level
  assign lo     = (trig_level > trig_hyst) ? trig_level - trig_hyst : '0;
  assign hi_sum = {1'b0, trig_level} + {1'b0, trig_hyst};
  assign hi     = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];

  assign beyond = trig_slope ? (s > hi) : (s < lo);
  assign hit    = trig_slope ? (s <= trig_level) : (s >= trig_level);

  assign stop_req  = (mode == 2'd3);
  assign post_len  = {ADDR_W{1'b1}} - pre_q;
  assign cnt_nxt   = cnt + ADDR_W'(1);
  assign to_nxt    = to_cnt + TO_W'(1);
  assign real_trig = arm_flag && hit;
  assign auto_trig = (mode == 2'd0) && (to_nxt == TO_W'(AUTO_TO));

  assign busy = state inside {S_PRE, S_WAIT, S_POST};
  assign done = (state == S_DONE);

  assign wr_en = din_valid && !stop_req &&
                 ((state == S_PRE) || (state == S_WAIT) ||
                  ((state == S_POST) && (post_len != '0)));

  assign start_cap =
    ((state == S_IDLE) &&
     ((mode == 2'd0) || (mode == 2'd1) || ((mode == 2'd2) && arm))) ||
    ((state == S_DONE) && !stop_req && (arm || (frame_ack && !mode[1])));

  assign rd_phys = trig_addr - pre_q + rd_addr;
  assign rd_word = mem[rd_phys];

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < CH; k++)
      if (rd_ch == CH_W'(k)) rd_sel = rd_word[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      pre_q     <= '0;
      cnt       <= '0;
      to_cnt    <= '0;
      trig_addr <= '0;
      arm_flag  <= 1'b0;
      triggered <= 1'b0;
      forced    <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_data <= rd_sel;
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (start_cap) begin
        pre_q     <= pre_len;
        cnt       <= '0;
        to_cnt    <= '0;
        arm_flag  <= 1'b0;
        triggered <= 1'b0;
        forced    <= 1'b0;
        state     <= (pre_len == '0) ? S_WAIT : S_PRE;
      end else if (stop_req && busy) begin
        state     <= S_IDLE;
        arm_flag  <= 1'b0;
        triggered <= 1'b0;
        forced    <= 1'b0;
      end else begin
        unique case (state)
          S_PRE: if (din_valid) begin
            if (beyond) arm_flag <= 1'b1;
            cnt <= cnt_nxt;
            if (cnt_nxt == pre_q) begin
              state  <= S_WAIT;
              to_cnt <= '0;
            end
          end
          S_WAIT: if (din_valid) begin
            if (mode == 2'd0) to_cnt <= to_nxt;
            if (real_trig || auto_trig) begin
              trig_addr <= wr_ptr;
              triggered <= 1'b1;
              forced    <= !real_trig;
              arm_flag  <= 1'b0;
              cnt       <= '0;
              state     <= S_POST;
            end else if (beyond) begin
              arm_flag <= 1'b1;
            end
          end
          S_POST: begin
            if (post_len == '0) begin
              state <= S_DONE;
            end else if (din_valid) begin
              cnt <= cnt_nxt;
              if (cnt_nxt == post_len) state <= S_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scope_capture_trig.sv
// Bench for scope_capture_trig: random sample streams against a
// sample-indexed trigger model, with a queued readout/status scoreboard.
module tb_scope_capture_trig;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int ATO   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2*DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic [1:0]    mode = 2'd3;
  logic          arm = 1'b0;
  logic          frame_ack = 1'b0;
  logic          trig_ch = 1'b0;
  logic          trig_slope = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic [DW-1:0] trig_hyst = '0;
  logic [AW-1:0] pre_len = '0;
  logic          rd_ch = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy, triggered, forced, done;

  always #5 clk = ~clk;

  scope_capture_trig #(
    .DATA_W(DW), .CH(2), .CH_W(1), .ADDR_W(AW), .AUTO_TO(ATO)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .mode(mode), .arm(arm), .frame_ack(frame_ack),
    .trig_ch(trig_ch), .trig_slope(trig_slope),
    .trig_level(trig_level), .trig_hyst(trig_hyst),
    .pre_len(pre_len), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .triggered(triggered),
    .forced(forced), .done(done)
  );

  typedef struct { string name; int exp; } rd_item_t;
  typedef struct { string name; logic [3:0] exp; int exp_rd; } st_item_t;

  rd_item_t rd_q[$];
  st_item_t st_q[$];
  int checks = 0;
  int failures = 0;
  logic rd_go = 1'b0;
  logic st_go = 1'b0;
  logic rd_pend = 1'b0;

  int q0[$];
  int q1[$];
  int c_pre, c_level, c_hyst, c_slope, c_ch, c_mode;
  bit in_done = 0;
  bit last_trg, last_frc;

  always @(posedge clk) rd_pend <= rd_go;

  always @(negedge clk) begin
    if (rd_pend) begin
      rd_item_t ri;
      logic [DW-1:0] e;
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%0d", rd_data);
      end else begin
        ri = rd_q.pop_front();
        e = DW'(ri.exp);
        if (rd_data !== e) begin
          failures++;
          $display("FAIL %s got=%0d exp=%0d", ri.name, rd_data, e);
        end
      end
    end
    if (st_go) begin
      st_item_t si;
      logic [3:0] act;
      checks++;
      act = {done, triggered, forced, busy};
      if (st_q.size() == 0) begin
        failures++;
        $display("FAIL st_unexpected got=%b", act);
      end else begin
        si = st_q.pop_front();
        if (act !== si.exp ||
            (si.exp_rd >= 0 && rd_data !== DW'(si.exp_rd))) begin
          failures++;
          $display("FAIL %s got(done,trig,forced,busy)=%b rd=%0d exp=%b rd=%0d",
                   si.name, act, rd_data, si.exp, si.exp_rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st_check(string nm, bit d, bit tr, bit fo, bit bu, int erd);
    st_item_t it;
    it.name = nm;
    it.exp = {d, tr, fo, bu};
    it.exp_rd = erd;
    st_q.push_back(it);
    st_go = 1'b1;
    tick();
    st_go = 1'b0;
  endtask

  task automatic rd_check(string nm, int ch, int a, int e);
    rd_item_t it;
    it.name = nm;
    it.exp = e;
    rd_q.push_back(it);
    rd_ch = ch[0];
    rd_addr = AW'(a);
    rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
  endtask

  task automatic apply_cfg();
    pre_len = AW'(c_pre);
    trig_level = DW'(c_level);
    trig_hyst = DW'(c_hyst);
    trig_slope = c_slope[0];
    trig_ch = c_ch[0];
  endtask

  task automatic clear_q();
    q0.delete();
    q1.delete();
  endtask

  task automatic start(int m);
    apply_cfg();
    c_mode = m;
    mode = 2'(m);
    arm = in_done || (m == 2);
    tick();
    arm = 1'b0;
    in_done = 0;
    clear_q();
  endtask

  task automatic stream(int from, int to);
    for (int i = from; i < to; i++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) tick();
      din = {DW'(q1[i]), DW'(q0[i])};
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
    end
  endtask

  // trigger index over accepted samples since capture start
  task automatic model(int n, output int t, output bit f);
    bit armed;
    int lo, hi, s;
    bit hit, real_t;
    armed = 0;
    t = -1;
    f = 0;
    lo = c_level - c_hyst;
    if (lo < 0) lo = 0;
    hi = c_level + c_hyst;
    if (hi > 255) hi = 255;
    for (int k = 0; k < n; k++) begin
      if (t < 0) begin
        s = (c_ch != 0) ? q1[k] : q0[k];
        if (k >= c_pre) begin
          hit = (c_slope != 0) ? (s <= c_level) : (s >= c_level);
          real_t = armed && hit;
          if (real_t || (c_mode == 0 && k == c_pre + ATO - 1)) begin
            t = k;
            f = !real_t;
          end
        end
        if ((c_slope != 0) ? (s > hi) : (s < lo)) armed = 1;
      end
    end
  endtask

  task automatic abort(string tag);
    mode = 2'd3;
    tick();
    st_check({tag, "_abort"}, 0, 0, 0, 0, -1);
    in_done = 0;
  endtask

  task automatic finish_capture(string tag, int n);
    int t, idx;
    bit f, trg, dn;
    tick();
    model(n, t, f);
    trg = (t >= 0);
    dn = trg && (t + DEPTH - 1 - c_pre < n);
    last_trg = trg;
    last_frc = trg && f;
    st_check({tag, "_status"}, dn, trg, trg && f, !dn, -1);
    if (dn) begin
      for (int ch = 0; ch < 2; ch++)
        for (int a = 0; a < DEPTH; a++) begin
          idx = t - c_pre + a;
          rd_check($sformatf("%s_rd_c%0d_a%0d", tag, ch, a), ch, a,
                   (ch != 0) ? q1[idx] : q0[idx]);
        end
      in_done = 1;
    end else begin
      abort(tag);
    end
  endtask

  task automatic rand_cfg();
    int h;
    c_pre = $urandom_range(0, 15);
    c_level = $urandom_range(0, 255);
    h = $urandom_range(0, 3);
    c_hyst = (h == 0) ? 0 : (h == 3) ? 255 : $urandom_range(0, 40);
    c_slope = $urandom_range(0, 1);
    c_ch = $urandom_range(0, 1);
  endtask

  task automatic gen_rand(int n);
    for (int i = 0; i < n; i++) begin
      q0.push_back($urandom_range(0, 255));
      q1.push_back($urandom_range(0, 255));
    end
  endtask

  initial begin
    int t;
    bit f;

    rst = 1'b1;
    mode = 2'd3;
    tick();
    tick();
    st_check("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // ramp through level 128, normal mode
    c_pre = 4; c_level = 128; c_hyst = 8; c_slope = 0; c_ch = 0;
    start(1);
    for (int i = 0; i < 60; i++) begin
      q0.push_back(100 + i);
      q1.push_back($urandom_range(0, 255));
    end
    stream(0, 60);
    finish_capture("ramp", 60);

    // falling: 55 never exceeds hi=60, so no arming until 61
    c_pre = 2; c_level = 50; c_hyst = 10; c_slope = 1; c_ch = 0;
    apply_cfg();
    c_mode = 1;
    mode = 2'd1;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    in_done = 0;
    clear_q();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(55);
      q1.push_back($urandom_range(0, 255));
    end
    for (int i = 0; i < 3; i++) begin
      q0.push_back(50);
      q1.push_back($urandom_range(0, 255));
    end
    stream(0, 9);
    tick();
    st_check("fall_hold", 0, 0, 0, 1, -1);
    q0.push_back(61); q1.push_back($urandom_range(0, 255));
    q0.push_back(50); q1.push_back($urandom_range(0, 255));
    gen_rand(20);
    stream(9, 31);
    finish_capture("fall", 31);

    // auto timeout on a flat input
    c_pre = 3; c_level = 128; c_hyst = 8; c_slope = 0; c_ch = 0;
    start(0);
    for (int i = 0; i < 50; i++) begin
      q0.push_back(8'h40);
      q1.push_back($urandom_range(0, 255));
    end
    stream(0, c_pre + ATO - 1);
    tick();
    st_check("auto_wait", 0, 0, 0, 1, -1);
    stream(c_pre + ATO - 1, 50);
    finish_capture("auto", 50);

    // single: frame_ack ignored, arm restarts
    mode = 2'd2;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    st_check("single_ack_ignored", 1, 1, 1, 0, -1);
    c_pre = 5; c_level = 128; c_hyst = 30; c_slope = 0; c_ch = 1;
    apply_cfg();
    c_mode = 2;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    in_done = 0;
    clear_q();
    st_check("single_rearm", 0, 0, 0, 1, -1);
    for (int i = 0; i < 60; i++) begin
      q0.push_back($urandom_range(0, 255));
      q1.push_back((i % 4 < 2) ? $urandom_range(0, 60)
                               : $urandom_range(200, 255));
    end
    stream(0, 60);
    finish_capture("single", 60);
    if (in_done) begin
      mode = 2'd3;
      tick();
      st_check("stop_holds_done", 1, last_trg, last_frc, 0, -1);
    end

    // stop during POST
    c_pre = 4; c_level = 128; c_hyst = 8; c_slope = 0; c_ch = 0;
    start(1);
    for (int i = 0; i < 60; i++) begin
      q0.push_back(100 + i);
      q1.push_back($urandom_range(0, 255));
    end
    model(60, t, f);
    stream(0, t + 3);
    tick();
    st_check("post_busy", 0, 1, 0, 1, -1);
    abort("post_stop");

    // randomized captures, pre_len extremes first
    for (int it = 0; it < 10; it++) begin
      rand_cfg();
      if (it == 0) c_pre = 0;
      if (it == 1) c_pre = 15;
      start((it == 0) ? 1 : $urandom_range(0, 1));
      gen_rand(60);
      stream(0, 60);
      finish_capture($sformatf("rnd%0d", it), 60);
    end

    // reset while streaming in WAIT
    c_pre = 2; c_level = 255; c_hyst = 0; c_slope = 0; c_ch = 0;
    start(1);
    for (int i = 0; i < 10; i++) begin
      q0.push_back($urandom_range(0, 200));
      q1.push_back($urandom_range(0, 255));
    end
    stream(0, 10);
    din = {8'd7, 8'd9};
    din_valid = 1'b1;
    rst = 1'b1;
    mode = 2'd3;
    tick();
    rst = 1'b0;
    din_valid = 1'b0;
    st_check("rst_wait", 0, 0, 0, 0, 0);
    in_done = 0;

    rand_cfg();
    start(1);
    gen_rand(60);
    stream(0, 60);
    finish_capture("after_rst", 60);

    tick();
    tick();
    tick();
    checks++;
    if (rd_q.size() != 0 || st_q.size() != 0) begin
      failures++;
      $display("FAIL drain rd_left=%0d st_left=%0d exp=0", rd_q.size(), st_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scope_capture_trig.md
Name: scope_capture_trig

Overview:
- Parametrised multi-channel triggered capture buffer for the oscilloscope datapath.
- Sits between the AD front end (real-time or equivalent-time sample stream) and the VGA/storage readout.
- Records a pre-trigger window and a post-trigger window into a circular RAM, using edge trigger with hysteresis.
- Supports auto, normal, single and stop modes, then freezes the frame for pixel-rate readout.

Parameters:
DATA_W, 8, sample width per channel
CH, 2, number of channels, captured in lockstep
CH_W, 1, width of channel-select ports (>= clog2(CH), min 1)
ADDR_W, 9, log2 of capture depth; DEPTH = 2**ADDR_W
AUTO_TO, 4096, auto-mode timeout in accepted samples while waiting for a trigger

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
din  in  CH*DATA_W  sample word; channel k occupies bits [k*DATA_W +: DATA_W]
din_valid  in  1  sample strobe (decimated sample enable)
mode  in  2  0 auto, 1 normal, 2 single, 3 stop
arm  in  1  one-cycle pulse; starts a single capture, or re-arms from DONE
frame_ack  in  1  one-cycle pulse; readout finished, allows re-arm in auto/normal
trig_ch  in  CH_W  trigger source channel
trig_slope  in  1  0 rising, 1 falling
trig_level  in  DATA_W  trigger threshold
trig_hyst  in  DATA_W  hysteresis band
pre_len  in  ADDR_W  pre-trigger samples, sampled on entry to PRE
rd_ch  in  CH_W  readout channel
rd_addr  in  ADDR_W  readout index; 0 is the oldest sample, pre_len is the trigger sample
rd_data  out  DATA_W  readout data, 1-cycle latency
busy  out  1  state is PRE, WAIT or POST
triggered  out  1  trigger taken in the current frame
forced  out  1  current frame was auto-forced
done  out  1  frame frozen and valid

Behaviour:
- Reset: state IDLE; wr_ptr, counters and trig_addr cleared to 0; all outputs 0.
  - RAM contents are not cleared.
  - Reset mid-capture aborts the frame.
- States:
  - IDLE: enter PRE if mode is 0 or 1, or if arm is pulsed with mode 2.
  - PRE: latch pre_len into pre_q. Write every valid sample. After pre_q writes, go to WAIT; pre_q = 0 goes directly to WAIT.
  - WAIT: write every valid sample and evaluate the trigger on it. On a trigger, latch trig_addr = wr_ptr of that sample, set triggered, go to POST.
  - POST: write DEPTH-1-pre_q further samples, then go to DONE. If that count is 0, go to DONE on the cycle after the trigger.
  - DONE: done = 1 and writes stop.
    - Mode 0 or 1: frame_ack → PRE.
    - Mode 2: arm → PRE.
    - arm is also accepted in modes 0 and 1.
    - Leaving DONE clears done, triggered and forced.
- mode = 3 forces PRE, WAIT or POST to IDLE on the next cycle. DONE holds in mode 3.
- Writes: address wr_ptr; wr_ptr increments by 1 mod DEPTH per valid write. All CH channels are written at the same address.
- Trigger uses the channel selected by trig_ch, sample s.
  - Thresholds are saturating: lo = max(level-hyst, 0), hi = min(level+hyst, 2**DATA_W-1).
  - Rising: arm_flag sets when s < lo. Trigger when arm_flag and s >= trig_level.
  - Falling: arm_flag sets when s > hi. Trigger when arm_flag and s <= trig_level.
  - arm_flag is tracked in PRE and WAIT, cleared on entry to PRE, and cleared on a trigger.
  - Hysteresis 0 still requires an opposite-side sample before a trigger.
- Auto timeout: in WAIT with mode 0, count valid samples.
  - When the count reaches AUTO_TO with no trigger, force a trigger on that sample: forced = 1, triggered = 1.
  - Counter is reset on entry to WAIT.
- Readout: physical address = (trig_addr - pre_q + rd_addr) mod DEPTH. rd_data is registered, 1 cycle after rd_addr/rd_ch.
  - Data is valid only while done = 1.
  - Reads are allowed in every state.
- Simultaneous events:
  - arm and frame_ack in the same cycle give a single re-arm.
  - A trigger condition on the PRE→WAIT cycle is not taken.
  - din_valid low stalls all counters.

Test Plan:
- DEPTH=16, pre_len=4, rising, level 128, hyst 8, ramp 100..160 step 1 on ch0, normal mode → trigger at sample value 128, rd_addr 4 reads 128, rd_addr 0 reads 124, rd_addr 15 reads 139, done=1 and forced=0.
- Falling slope, level 50, hyst 10, input holds at 55 and then drops to 50 → no trigger, because 55 never exceeds hi=60. After the input goes to 61 and then 50 → trigger.
- Auto mode, AUTO_TO=32, constant input 0x40 → forced=1 and triggered=1 once 32 valid samples have passed in WAIT, then done.
- Single mode: first frame done, frame_ack alone has no effect; an arm pulse restarts capture and done drops on the next cycle.
- Mode set to 3 during POST → IDLE next cycle, busy=0, done=0. Returning to mode 1 gives a new capture.
- rst asserted during WAIT with din_valid streaming → all outputs 0 next cycle, wr_ptr restarts at 0. CH=2 check: ch1 data at trigger index equals the ch1 sample co-timed with the ch0 trigger.
